// File: rtl/commit_checker_if.sv
// Commit-checker stream interface: expected-commit push channel from the
// golden model plus the DUT commit stream.
//   master : golden model / CPU side (drives exp_*, dut_*, halt_i)
//   slave  : commit_checker (drives exp_ready_o)
interface commit_checker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              exp_valid_i;
  logic              exp_ready_o;
  logic [DATA_W-1:0] exp_pc_i;
  logic              exp_we_i;
  logic [ADDR_W-1:0] exp_waddr_i;
  logic [DATA_W-1:0] exp_wdata_i;
  logic              dut_valid_i;
  logic [DATA_W-1:0] dut_pc_i;
  logic              dut_we_i;
  logic [ADDR_W-1:0] dut_waddr_i;
  logic [DATA_W-1:0] dut_wdata_i;
  logic              halt_i;

  modport master (
    output exp_valid_i, exp_pc_i, exp_we_i, exp_waddr_i, exp_wdata_i,
    output dut_valid_i, dut_pc_i, dut_we_i, dut_waddr_i, dut_wdata_i,
    output halt_i,
    input  exp_ready_o
  );

  modport slave (
    input  exp_valid_i, exp_pc_i, exp_we_i, exp_waddr_i, exp_wdata_i,
    input  dut_valid_i, dut_pc_i, dut_we_i, dut_waddr_i, dut_wdata_i,
    input  halt_i,
    output exp_ready_o
  );
endinterface

// File: rtl/commit_checker.sv
// Commit-stream checker for the single-cycle CPU. Expected commits from a
// golden model are queued in a FIFO; every DUT commit pops the oldest entry
// and compares next PC and register-file write.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   start_i        one-cycle pulse: clear state and start a run (ignored in RUN)
//   bus            commit_checker_if.slave: exp_* push channel, dut_* commit, halt_i
//   busy_o         run in progress
//   done_o         run finished (DONE or FAIL)
//   pass_o         run finished without error
//   err_o          sticky error flag
//   err_kind_o     first error: 0 none, 1 PC, 2 write, 3 underflow, 4 overflow
//   err_index_o    checked count at the first error
//   checked_cnt_o  commits compared (saturating)
//   mismatch_cnt_o errors counted (saturating)
//
// Optional feature: define STOP_ON_MISMATCH_EN to stop the run (FAIL state)
// on the first error; otherwise errors are counted and the run continues.
module commit_checker #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned END_COUNT  = 25,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  commit_checker_if.slave    bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               err_o,
  output logic [2:0]         err_kind_o,
  output logic [CNT_W-1:0]   err_index_o,
  output logic [CNT_W-1:0]   checked_cnt_o,
  output logic [CNT_W-1:0]   mismatch_cnt_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(END_COUNT);

  localparam logic [2:0] KIND_NONE  = 3'd0;
  localparam logic [2:0] KIND_PC    = 3'd1;
  localparam logic [2:0] KIND_WRITE = 3'd2;
  localparam logic [2:0] KIND_UNDER = 3'd3;
  localparam logic [2:0] KIND_OVER  = 3'd4;

`ifdef STOP_ON_MISMATCH_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } commit_t;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_d, busy_d, done_d, pass_d, ready_d, ready_q;
  logic [2:0]        err_kind_d;
  logic [CNT_W-1:0]  err_index_d, checked_d, mismatch_d;
  commit_t           mem_q [FIFO_DEPTH];
  commit_t           head, push_entry;

  logic in_run, full, empty, commit, pop, push, overflow, wr_bad;
  logic [2:0] cur_kind;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stream qualification; a full FIFO still accepts a push when a pop frees a slot
  assign in_run   = (state_q == S_RUN);
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign commit   = in_run && bus.dut_valid_i;
  assign pop      = commit && !empty;
  assign push     = in_run && bus.exp_valid_i && (!full || pop);
  assign overflow = in_run && bus.exp_valid_i && full && !pop;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = bus.exp_pc_i;
    push_entry.we    = bus.exp_we_i;
    push_entry.waddr = bus.exp_waddr_i;
    push_entry.wdata = bus.exp_wdata_i;
  end

  // Write compare: enables must agree; r0 writes compare the enable only
  assign wr_bad = (bus.dut_we_i != head.we) ||
                  (head.we && ((bus.dut_waddr_i != head.waddr) ||
                               ((head.waddr != '0) && (bus.dut_wdata_i != head.wdata))));

  // Error classification for this cycle; overflow cannot coincide with a commit
  always_comb begin
    cur_kind = KIND_NONE;
    if (commit) begin
      if (empty)                             cur_kind = KIND_UNDER;
      else if (bus.dut_pc_i != head.pc)      cur_kind = KIND_PC;
      else if (wr_bad)                       cur_kind = KIND_WRITE;
    end else if (overflow) begin
      cur_kind = KIND_OVER;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_d       = err_o;
    err_kind_d  = err_kind_o;
    err_index_d = err_index_o;
    checked_d   = checked_cnt_o;
    mismatch_d  = mismatch_cnt_o;

    case (state_q)
      S_RUN: begin
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (commit) checked_d = sat_inc(checked_cnt_o);
        if (cur_kind != KIND_NONE) begin
          mismatch_d = sat_inc(mismatch_cnt_o);
          if (!err_o) begin
            err_d       = 1'b1;
            err_kind_d  = cur_kind;
            err_index_d = checked_cnt_o;
          end
        end
        if (STOP_ON_ERR && (cur_kind != KIND_NONE)) begin
          state_d = S_FAIL;
        end else if (commit && ((checked_d == END_CNT) || bus.halt_i)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (start_i) begin
          state_d     = S_RUN;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          err_d       = 1'b0;
          err_kind_d  = KIND_NONE;
          err_index_d = '0;
          checked_d   = '0;
          mismatch_d  = '0;
        end
      end
    endcase

    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE) || (state_d == S_FAIL);
    pass_d  = (state_d == S_DONE) && !err_d;
    ready_d = (state_d == S_RUN) && (count_d != FULL_CNT);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ready_q        <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      pass_o         <= 1'b0;
      err_o          <= 1'b0;
      err_kind_o     <= KIND_NONE;
      err_index_o    <= '0;
      checked_cnt_o  <= '0;
      mismatch_cnt_o <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ready_q        <= ready_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      pass_o         <= pass_d;
      err_o          <= err_d;
      err_kind_o     <= err_kind_d;
      err_index_o    <= err_index_d;
      checked_cnt_o  <= checked_d;
      mismatch_cnt_o <= mismatch_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign bus.exp_ready_o = ready_q;

endmodule
